// File: rtl/core8_button_pio_pkg.sv
// Shared constants for the button/switch input PIO: register addresses,
// edge-type selectors and the debounce counter sizing helper.
package core8_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/core8_button_pio_if.sv
// Avalon-MM slave bus plus interrupt line of the button input PIO.
interface core8_button_pio_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface

// File: rtl/core8_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a stable-count debouncer.
module core8_debounce_bit
    import core8_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic db
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign db = sync2;
        end else begin : g_debounce
            localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          db_q;

            // Level is only accepted after DEBOUNCE_CYCLES consecutive mismatches.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt  <= '0;
                    db_q <= RESET_LEVEL;
                end else if (sync2 == db_q) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    db_q <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign db = db_q;
        end
    endgenerate

endmodule

// File: rtl/core8_button_pio.sv
// Debounced push-button/switch input port with per-bit edge capture and a
// maskable level interrupt on an Avalon-MM slave.
module core8_button_pio
    import core8_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   in_port,
    core8_button_pio_if.slave  bus
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        core8_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b1)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (in_port[i]),
            .db      (db[i])
        );
    end

    assign wr_en        = bus.chipselect && !bus.write_n;
    assign unused_wdata = ^bus.writedata[31:WIDTH];

    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            int'(EDGE_RISE): edge_evt = db & ~db_d;
            int'(EDGE_FALL): edge_evt = ~db & db_d;
            default:         edge_evt = db ^ db_d;
        endcase
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && bus.address == PIO_ADDR_EDGE)
            clr_bits = bus.writedata[WIDTH-1:0];
    end

    // Set is OR-ed in after the clear so a same-cycle event wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_d     <= '1;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            db_d     <= db;
            edge_cap <= (edge_cap & ~clr_bits) | edge_evt;
            if (wr_en && bus.address == PIO_ADDR_MASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            PIO_ADDR_DATA: bus.readdata[WIDTH-1:0] = db;
            PIO_ADDR_MASK: bus.readdata[WIDTH-1:0] = irq_mask;
            PIO_ADDR_EDGE: bus.readdata[WIDTH-1:0] = edge_cap;
            default:       bus.readdata = '0;
        endcase
    end

    assign bus.irq = |(edge_cap & irq_mask);

endmodule
